serial_rcv: RTL and testbench

Asynchronous serial frame receiver (1 start bit, DATA_BITS data bits LSB-first, 1 stop bit; idle line high). It sits directly downstream of the two-flop input synchronizer: it consumes the synchronized line, recovers bit timing from a fixed clocks-per-bit count, and presents each received byte with a ready flag and error flags to the consuming logic, which acknowledges via `data_read`.

---
 rtl/serial_rcv_pkg.sv | 17 +
 rtl/rcv_bit_timer.sv | 29 ++
 rtl/serial_rcv.sv | 156 +++++++++++++++
 tb/tb_serial_rcv.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_rcv_pkg.sv
// Shared types and helpers for the serial frame receiver.
package serial_rcv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    // The timer must be able to hold a full CLKS_PER_BIT reload value.
    function automatic int timer_width(input int clks_per_bit);
        return $clog2(clks_per_bit + 1);
    endfunction

endpackage

// File: rtl/rcv_bit_timer.sv
// Loadable down-counter; expire is high while the count sits at 1, so a
// reload issued on that cycle leaves no dead cycle between bit periods.
module rcv_bit_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - ONE;
        end
    end

    assign expire = (count == ONE);

endmodule

// File: rtl/serial_rcv.sv
// Asynchronous serial frame receiver: start bit, DATA_BITS data bits LSB-first,
// stop bit, with data-ready handshake and overrun/framing flags.
module serial_rcv
    import serial_rcv_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun_error,
    output logic                 framing_error,
    output logic                 rx_busy
);

    localparam int              TW       = timer_width(CLKS_PER_BIT);
    localparam logic [TW-1:0]   HALF     = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0]   FULL     = TW'(CLKS_PER_BIT);
    localparam int              BW       = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0]   BIT_ONE  = BW'(1);

    state_t                 state;
    state_t                 next_state;
    logic                   prev;
    logic [DATA_BITS-1:0]   shift;
    logic [BW-1:0]          bit_cnt;
    logic                   expire;
    logic                   load;
    logic [TW-1:0]          load_val;
    logic                   start_edge;
    logic                   shift_en;
    logic                   clr_bits;
    logic                   commit;
    logic                   set_fe;
    logic                   clr_fe;

    rcv_bit_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .expire   (expire)
    );

    assign start_edge = (state == IDLE) && !serial_in && prev;
    assign rx_busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        load_val   = FULL;
        shift_en   = 1'b0;
        clr_bits   = 1'b0;
        commit     = 1'b0;
        set_fe     = 1'b0;
        clr_fe     = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    load       = 1'b1;
                    load_val   = HALF;
                    clr_fe     = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                if (expire) begin
                    if (!serial_in) begin
                        load       = 1'b1;
                        clr_bits   = 1'b1;
                        next_state = DATA;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            DATA: begin
                // The reload on the last data bit times the stop-bit sample.
                if (expire) begin
                    shift_en = 1'b1;
                    load     = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        next_state = STOP;
                    end
                end
            end
            STOP: begin
                if (expire) begin
                    if (serial_in) begin
                        commit     = 1'b1;
                        next_state = IDLE;
                    end else begin
                        set_fe     = 1'b1;
                        next_state = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (serial_in) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev          <= 1'b1;
            shift         <= '0;
            bit_cnt       <= '0;
            rx_data       <= '0;
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            prev <= serial_in;
            if (clr_bits) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + BIT_ONE;
            end
            if (shift_en) begin
                shift <= {serial_in, shift[DATA_BITS-1:1]};
            end
            if (clr_fe) begin
                framing_error <= 1'b0;
            end else if (set_fe) begin
                framing_error <= 1'b1;
            end
            // A commit wins over a same-cycle read; the read only cancels the overrun.
            if (commit) begin
                rx_data       <= shift;
                data_ready    <= 1'b1;
                overrun_error <= data_ready && !data_read;
            end else if (data_read && data_ready) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_rcv.sv
// Self-checking bench for serial_rcv: directed frames plus randomized traffic
// compared every cycle against a frame-timing model of the receiver.
module tb_serial_rcv;

    localparam int C    = 10;
    localparam int DB   = 8;
    localparam int HALF = C / 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          serial_in = 1'b1;
    logic          data_read = 1'b0;
    logic [DB-1:0] rx_data;
    logic          data_ready;
    logic          overrun_error;
    logic          framing_error;
    logic          rx_busy;

    serial_rcv #(.CLKS_PER_BIT(C), .DATA_BITS(DB)) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .data_read     (data_read),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .overrun_error (overrun_error),
        .framing_error (framing_error),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int t_start = 0;
    int rise_cyc = -1;
    bit last_ready = 1'b0;
    bit rand_rd_en = 1'b0;

    // Model state: a frame is tracked by the cycle of its start edge.
    bit          m_active = 1'b0;
    bit          m_wait = 1'b0;
    bit          m_prev = 1'b1;
    int          m_t0 = 0;
    logic [DB-1:0] m_shift = '0;
    logic [DB-1:0] m_rx = '0;
    bit          m_ready = 1'b0;
    bit          m_ovr = 1'b0;
    bit          m_fe = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit dr);
        int off;
        int k;
        bit commit;
        if (r) begin
            m_active = 1'b0; m_wait = 1'b0; m_prev = 1'b1;
            m_rx = '0; m_ready = 1'b0; m_ovr = 1'b0; m_fe = 1'b0; m_shift = '0;
            return;
        end
        commit = 1'b0;
        if (m_active) begin
            off = cyc - m_t0;
            if (off == HALF) begin
                if (s) m_active = 1'b0;
            end else if (off > HALF && (off - HALF) % C == 0) begin
                k = (off - HALF) / C - 1;
                if (k < DB) begin
                    m_shift[k] = s;
                end else begin
                    m_active = 1'b0;
                    if (s) commit = 1'b1;
                    else begin
                        m_fe = 1'b1;
                        m_wait = 1'b1;
                    end
                end
            end
        end else if (m_wait) begin
            if (s) m_wait = 1'b0;
        end else if (!s && m_prev) begin
            m_active = 1'b1;
            m_t0 = cyc;
            m_fe = 1'b0;
        end
        if (commit) begin
            m_ovr = m_ready && !dr;
            m_ready = 1'b1;
            m_rx = m_shift;
        end else if (dr && m_ready) begin
            m_ready = 1'b0;
            m_ovr = 1'b0;
        end
        m_prev = s;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step(rst, serial_in, data_read);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                check("rx_data", 32'(rx_data), 32'(m_rx));
                check("data_ready", 32'(data_ready), 32'(m_ready));
                check("overrun_error", 32'(overrun_error), 32'(m_ovr));
                check("framing_error", 32'(framing_error), 32'(m_fe));
                check("rx_busy", 32'(rx_busy), 32'(m_active || m_wait));
                if (data_ready && !last_ready) rise_cyc = cyc;
                last_ready = data_ready;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_rd_en) data_read = ($urandom_range(0, 9) == 0);
        end
    end

    // Element i of the frame is applied to posedge t+i; rst_at>0 aborts there with a reset.
    task automatic send_frame(input logic [DB-1:0] d, input bit stop, input bit rd_at_stop,
                              input int rst_at);
        for (int i = 0; i < (DB + 2) * C; i++) begin
            int b = i / C;
            if (i == 0) t_start = cyc + 1;
            if (b == 0) serial_in = 1'b0;
            else if (b <= DB) serial_in = d[b-1];
            else serial_in = stop;
            if (rd_at_stop) data_read = (i == (DB + 1) * C + HALF);
            if (rst_at > 0 && i == rst_at) begin
                rst = 1'b1;
                serial_in = 1'b1;
            end
            @(negedge clk);
            if (rst) begin
                rst = 1'b0;
                return;
            end
        end
        if (rd_at_stop) data_read = 1'b0;
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_read();
        data_read = 1'b1;
        @(negedge clk);
        data_read = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        int kind;
        repeat (2) @(negedge clk);
        check("reset_rx_data", 32'(rx_data), 32'h0);
        check("reset_data_ready", 32'(data_ready), 32'h0);
        check("reset_busy", 32'(rx_busy), 32'h0);
        rst = 1'b0;
        idle(5);

        send_frame(8'hA5, 1'b1, 1'b0, 0);
        check("a5_ready_cycle", 32'(rise_cyc), 32'(t_start + 95));
        check("a5_rx_data", 32'(rx_data), 32'hA5);
        check("a5_ready", 32'(data_ready), 32'h1);
        check("a5_errors", 32'({overrun_error, framing_error}), 32'h0);
        pulse_read();
        check("a5_read_clears", 32'(data_ready), 32'h0);

        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            serial_in = (i < 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (rx_busy) busy_cnt++;
        end
        check("glitch_busy_cycles", 32'(busy_cnt), 32'd5);

        send_frame(8'h3C, 1'b0, 1'b0, 0);
        serial_in = 1'b0;
        repeat (30) @(negedge clk);
        check("fe_flag", 32'(framing_error), 32'h1);
        check("fe_rx_kept", 32'(rx_data), 32'hA5);
        check("fe_wait_high", 32'(rx_busy), 32'h1);
        idle(5);
        check("fe_released", 32'(rx_busy), 32'h0);
        send_frame(8'h11, 1'b1, 1'b0, 0);
        check("after_fe_rx", 32'(rx_data), 32'h11);
        check("after_fe_flag", 32'(framing_error), 32'h0);
        pulse_read();

        send_frame(8'h01, 1'b1, 1'b0, 0);
        send_frame(8'hFF, 1'b1, 1'b0, 0);
        check("ovr_rx", 32'(rx_data), 32'hFF);
        check("ovr_flags", 32'({data_ready, overrun_error}), 32'h3);
        pulse_read();
        check("ovr_cleared", 32'({data_ready, overrun_error}), 32'h0);

        send_frame(8'h22, 1'b1, 1'b0, 0);
        send_frame(8'h55, 1'b1, 1'b1, 0);
        check("same_cycle_rx", 32'(rx_data), 32'h55);
        check("same_cycle_flags", 32'({data_ready, overrun_error}), 32'h2);
        pulse_read();

        send_frame(8'h77, 1'b1, 1'b0, 40);
        check("midreset_outputs",
              32'({rx_data, data_ready, overrun_error, framing_error, rx_busy}), 32'h0);
        idle(20);
        send_frame(8'h77, 1'b1, 1'b0, 0);
        check("post_reset_rx", 32'(rx_data), 32'h77);
        check("post_reset_ready", 32'(data_ready), 32'h1);
        pulse_read();

        rand_rd_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 19);
            if (kind == 0) begin
                serial_in = 1'b0;
                repeat ($urandom_range(1, HALF - 1)) @(negedge clk);
            end else if (kind == 1) begin
                send_frame(DB'($urandom), 1'b1, 1'b0, $urandom_range(1, (DB + 2) * C - 1));
            end else if (kind <= 3) begin
                send_frame(DB'($urandom), 1'b0, 1'b0, 0);
                repeat ($urandom_range(0, 20)) @(negedge clk);
            end else begin
                send_frame(DB'($urandom), 1'b1, 1'b0, 0);
            end
            idle($urandom_range(0, 12));
        end
        rand_rd_en = 1'b0;
        data_read = 1'b0;
        idle(3 * C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
